// File: rtl/archon_ovr_pkg.sv
// Shared types and constants for the override sequencer: FSM states, posture
// codes, config bus addresses and hazard level codes.
package archon_ovr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STALL    = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_COOLDOWN = 3'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    POST_NORMAL   = 2'd0,
    POST_MONITOR  = 2'd1,
    POST_HIGH     = 2'd2,
    POST_CRITICAL = 2'd3
  } posture_e;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MED  = 2'd2,
    LVL_CRIT = 2'd3
  } hazard_level_e;

  localparam logic [1:0] CFG_ADDR_FLUSH_THR = 2'd0;
  localparam logic [1:0] CFG_ADDR_STALL_THR = 2'd1;
  localparam logic [1:0] CFG_ADDR_POSTURE   = 2'd2;
  localparam logic [1:0] CFG_ADDR_CLR_ESC   = 2'd3;

endpackage

// File: rtl/archon_threshold_scaler.sv
// Combinational posture scaling of a base threshold: higher postures lower the
// threshold so the override unit reacts earlier.
module archon_threshold_scaler
  import archon_ovr_pkg::*;
#(
  parameter int THR_W = 21
) (
  input  logic [THR_W-1:0] base,
  input  logic [1:0]       posture,
  output logic [THR_W-1:0] scaled
);

  always_comb begin
    scaled = base;
    case (posture)
      POST_NORMAL:   scaled = base;
      POST_MONITOR:  scaled = base - (base >> 3);
      POST_HIGH:     scaled = base - (base >> 2);
      POST_CRITICAL: scaled = base >> 1;
      default:       scaled = base;
    endcase
  end

endmodule

// File: rtl/archon_override_sequencer.sv
// Turns hazard override flush/stall requests into pipeline control and drives
// the override unit's posture and thresholds. Optional stats: ARCHON_OVR_STATS_EN.
module archon_override_sequencer
  import archon_ovr_pkg::*;
#(
  parameter int               THR_W          = 21,
  parameter logic [THR_W-1:0] DEF_FLUSH_THR  = THR_W'(400000),
  parameter logic [THR_W-1:0] DEF_STALL_THR  = THR_W'(150000),
  parameter int               STALL_HOLD_CYC = 4,
  parameter int               COOLDOWN_CYC   = 8,
  parameter int               ESC_LIMIT      = 3,
  parameter int               ESC_WINDOW     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [THR_W-1:0] cfg_wdata,
  input  logic [1:0]       ml_action_in,
  input  logic             aho_flush_req,
  input  logic             aho_stall_req,
  input  logic [1:0]       aho_level,
  output logic             pipe_flush_req,
  input  logic             pipe_flush_ack,
  output logic             pipe_stall,
  output logic [1:0]       ml_predicted_action,
  output logic [THR_W-1:0] scaled_flush_threshold,
  output logic [THR_W-1:0] scaled_stall_threshold,
  output logic [2:0]       seq_state,
  output logic [1:0]       esc_count
`ifdef ARCHON_OVR_STATS_EN
  ,
  output logic [15:0]      stat_flush_cnt,
  output logic [15:0]      stat_stall_cnt,
  output logic [15:0]      stat_esc_cnt
`endif
);

  localparam int HOLD_W = $clog2(STALL_HOLD_CYC + 1);
  localparam int CD_W   = $clog2(COOLDOWN_CYC + 1);
  localparam int IDLE_W = $clog2(ESC_WINDOW + 1);

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [1:0]        esc_q, esc_d, esc_inc;
  logic [THR_W-1:0]  base_flush_q, base_stall_q;
  logic [THR_W-1:0]  scaled_flush_c, scaled_stall_c;
  logic              ovr_en_q;
  logic [1:0]        ovr_val_q;
  logic [1:0]        eff_posture;

  assign eff_posture = ovr_en_q ? ovr_val_q : ml_action_in;
  assign esc_inc     = (esc_q == 2'd3) ? 2'd3 : esc_q + 2'd1;
  assign seq_state   = state_q;
  assign esc_count   = esc_q;

  archon_threshold_scaler #(.THR_W(THR_W)) u_flush_scaler (
    .base    (base_flush_q),
    .posture (eff_posture),
    .scaled  (scaled_flush_c)
  );

  archon_threshold_scaler #(.THR_W(THR_W)) u_stall_scaler (
    .base    (base_stall_q),
    .posture (eff_posture),
    .scaled  (scaled_stall_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_flush_q <= DEF_FLUSH_THR;
      base_stall_q <= DEF_STALL_THR;
      ovr_en_q     <= 1'b0;
      ovr_val_q    <= POST_NORMAL;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_ADDR_FLUSH_THR: base_flush_q <= cfg_wdata;
        CFG_ADDR_STALL_THR: base_stall_q <= cfg_wdata;
        CFG_ADDR_POSTURE: begin
          ovr_en_q  <= cfg_wdata[2];
          ovr_val_q <= cfg_wdata[1:0];
        end
        default: ;
      endcase
    end
  end

  // Posture and thresholds only track their sources while idle, so an
  // in-flight episode sees a stable configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ml_predicted_action    <= POST_NORMAL;
      scaled_flush_threshold <= DEF_FLUSH_THR;
      scaled_stall_threshold <= DEF_STALL_THR;
    end else if (state_q == ST_IDLE) begin
      ml_predicted_action    <= eff_posture;
      scaled_flush_threshold <= scaled_flush_c;
      scaled_stall_threshold <= scaled_stall_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      cd_q           <= '0;
      idle_q         <= '0;
      esc_q          <= '0;
      pipe_stall     <= 1'b0;
      pipe_flush_req <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      cd_q           <= cd_d;
      idle_q         <= idle_d;
      esc_q          <= esc_d;
      pipe_stall     <= (state_d == ST_STALL) || (state_d == ST_FLUSH);
      pipe_flush_req <= (state_d == ST_FLUSH);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cd_d    = cd_q;
    idle_d  = '0;
    esc_d   = esc_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_q == IDLE_W'(ESC_WINDOW - 1)) begin
          esc_d = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
        if (aho_flush_req) begin
          state_d = ST_FLUSH;
          idle_d  = '0;
        end else if (aho_stall_req) begin
          state_d = ST_STALL;
          hold_d  = HOLD_W'(STALL_HOLD_CYC);
          idle_d  = '0;
        end
      end
      ST_STALL: begin
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        if (aho_flush_req) begin
          state_d = ST_FLUSH;
        end else if ((hold_q <= HOLD_W'(1)) && !aho_stall_req) begin
          if (int'(esc_inc) >= ESC_LIMIT) begin
            state_d = ST_FLUSH;
            esc_d   = '0;
          end else begin
            state_d = ST_IDLE;
            esc_d   = esc_inc;
          end
        end
      end
      ST_FLUSH: begin
        if (pipe_flush_ack && pipe_flush_req) begin
          state_d = ST_COOLDOWN;
          cd_d    = CD_W'(COOLDOWN_CYC);
          esc_d   = '0;
        end
      end
      ST_COOLDOWN: begin
        if (cd_q != '0) cd_d = cd_q - CD_W'(1);
        if (aho_flush_req && (aho_level == LVL_CRIT)) begin
          state_d = ST_FLUSH;
        end else if (cd_q <= CD_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // An explicit clear from the config bus overrides any count update.
    if (cfg_we && (cfg_addr == CFG_ADDR_CLR_ESC)) esc_d = '0;
  end

`ifdef ARCHON_OVR_STATS_EN
  logic flush_entry, stall_entry, esc_flush;

  assign flush_entry = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
  assign stall_entry = (state_d == ST_STALL) && (state_q != ST_STALL);
  assign esc_flush   = (state_q == ST_STALL) && (state_d == ST_FLUSH) && !aho_flush_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flush_cnt <= '0;
      stat_stall_cnt <= '0;
      stat_esc_cnt   <= '0;
    end else if (cfg_we && (cfg_addr == CFG_ADDR_CLR_ESC)) begin
      stat_flush_cnt <= '0;
      stat_stall_cnt <= '0;
      stat_esc_cnt   <= '0;
    end else begin
      if (flush_entry && (stat_flush_cnt != 16'hFFFF)) stat_flush_cnt <= stat_flush_cnt + 16'd1;
      if (stall_entry && (stat_stall_cnt != 16'hFFFF)) stat_stall_cnt <= stat_stall_cnt + 16'd1;
      if (esc_flush && (stat_esc_cnt != 16'hFFFF))     stat_esc_cnt   <= stat_esc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_archon_override_sequencer.sv
// Self-checking bench for archon_override_sequencer: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_archon_override_sequencer;

  localparam int HOLD   = 4;
  localparam int CD     = 8;
  localparam int LIMIT  = 3;
  localparam int WINDOW = 64;
  localparam int DEF_F  = 400000;
  localparam int DEF_S  = 150000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [20:0] cfg_wdata;
  logic [1:0]  ml_action_in;
  logic        aho_flush_req;
  logic        aho_stall_req;
  logic [1:0]  aho_level;
  logic        pipe_flush_req;
  logic        pipe_flush_ack;
  logic        pipe_stall;
  logic [1:0]  ml_predicted_action;
  logic [20:0] scaled_flush_threshold;
  logic [20:0] scaled_stall_threshold;
  logic [2:0]  seq_state;
  logic [1:0]  esc_count;

  int checks = 0;
  int errors = 0;

  archon_override_sequencer dut (
    .clk                    (clk),
    .rst                    (rst),
    .cfg_we                 (cfg_we),
    .cfg_addr               (cfg_addr),
    .cfg_wdata              (cfg_wdata),
    .ml_action_in           (ml_action_in),
    .aho_flush_req          (aho_flush_req),
    .aho_stall_req          (aho_stall_req),
    .aho_level              (aho_level),
    .pipe_flush_req         (pipe_flush_req),
    .pipe_flush_ack         (pipe_flush_ack),
    .pipe_stall             (pipe_stall),
    .ml_predicted_action    (ml_predicted_action),
    .scaled_flush_threshold (scaled_flush_threshold),
    .scaled_stall_threshold (scaled_stall_threshold),
    .seq_state              (seq_state),
    .esc_count              (esc_count)
  );

  always #5 clk = ~clk;

  // Model state: mode 0..3 = idle/stall/flush/cooldown, age = cycles spent in
  // the current mode including this one.
  typedef struct packed {
    int st;
    int age;
    int esc;
    int post;
    int sflush;
    int sstall;
    int bflush;
    int bstall;
    int ov_en;
    int ov_val;
  } model_t;

  model_t m;

  // B - floor(B/8) == ceil(7B/8), B - floor(B/4) == ceil(3B/4).
  function automatic int scale_ref(input int b, input int p);
    case (p)
      0:       return b;
      1:       return (7 * b + 7) / 8;
      2:       return (3 * b + 3) / 4;
      default: return b / 2;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.age = 1; r.esc = 0; r.post = 0;
    r.sflush = DEF_F; r.sstall = DEF_S;
    r.bflush = DEF_F; r.bstall = DEF_S;
    r.ov_en = 0; r.ov_val = 0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c);
    model_t n;
    int eff;
    int inc;
    n = c;
    eff = (c.ov_en != 0) ? c.ov_val : int'(ml_action_in);
    case (c.st)
      0: begin
        if (c.age % WINDOW == 0) n.esc = 0;
        if (aho_flush_req) n.st = 2;
        else if (aho_stall_req) n.st = 1;
        n.post   = eff;
        n.sflush = scale_ref(c.bflush, eff);
        n.sstall = scale_ref(c.bstall, eff);
      end
      1: begin
        if (aho_flush_req) n.st = 2;
        else if (c.age >= HOLD && !aho_stall_req) begin
          inc = (c.esc + 1 > 3) ? 3 : c.esc + 1;
          if (inc >= LIMIT) begin
            n.st = 2; n.esc = 0;
          end else begin
            n.st = 0; n.esc = inc;
          end
        end
      end
      2: if (pipe_flush_ack) begin n.st = 3; n.esc = 0; end
      default: begin
        if (aho_flush_req && aho_level == 2'b11) n.st = 2;
        else if (c.age >= CD) n.st = 0;
      end
    endcase
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: n.bflush = int'(cfg_wdata);
        2'd1: n.bstall = int'(cfg_wdata);
        2'd2: begin n.ov_en = int'(cfg_wdata[2]); n.ov_val = int'(cfg_wdata[1:0]); end
        default: n.esc = 0;
      endcase
    end
    n.age = (n.st == c.st) ? c.age + 1 : 1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("model_seq_state", int'(seq_state), m.st);
    checkOutput("model_pipe_stall", int'(pipe_stall), (m.st == 1 || m.st == 2) ? 1 : 0);
    checkOutput("model_pipe_flush_req", int'(pipe_flush_req), (m.st == 2) ? 1 : 0);
    checkOutput("model_esc_count", int'(esc_count), m.esc);
    checkOutput("model_posture", int'(ml_predicted_action), m.post);
    checkOutput("model_scaled_flush", int'(scaled_flush_threshold), m.sflush);
    checkOutput("model_scaled_stall", int'(scaled_stall_threshold), m.sstall);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyStimulus(input logic f, input logic s, input logic [1:0] lvl,
                               input logic [1:0] ml, input logic ack);
    aho_flush_req  = f;
    aho_stall_req  = s;
    aho_level      = lvl;
    ml_action_in   = ml;
    pipe_flush_ack = ack;
  endtask

  task automatic setCfg(input logic we, input logic [1:0] addr, input logic [20:0] data);
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = data;
  endtask

  task automatic runEpisode();
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
    for (int i = 0; i < 20 && seq_state == 3'd1; i++) stepCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int frozen;
    rst = 1'b0;
    setCfg(1'b0, 2'd0, 21'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1 rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Reset state and default thresholds
    stepCycle();
    stepCycle();
    checkOutput("rst_seq_state", int'(seq_state), 0);
    checkOutput("rst_pipe_stall", int'(pipe_stall), 0);
    checkOutput("rst_flush_req", int'(pipe_flush_req), 0);
    checkOutput("rst_esc_count", int'(esc_count), 0);
    checkOutput("rst_posture", int'(ml_predicted_action), 0);
    checkOutput("rst_scaled_flush", int'(scaled_flush_threshold), 400000);
    checkOutput("rst_scaled_stall", int'(scaled_stall_threshold), 150000);

    // Posture override forces MONITOR regardless of the ML input
    setCfg(1'b1, 2'd2, 21'd5);
    stepCycle();
    setCfg(1'b0, 2'd0, 21'd0);
    stepCycle();
    checkOutput("ovr_posture", int'(ml_predicted_action), 1);
    checkOutput("ovr_scaled_flush", int'(scaled_flush_threshold), 350000);
    checkOutput("ovr_scaled_stall", int'(scaled_stall_threshold), 131250);
    setCfg(1'b1, 2'd2, 21'd0);
    stepCycle();
    setCfg(1'b0, 2'd0, 21'd0);
    stepCycle();

    // CRITICAL posture halves thresholds; frozen during a stall episode
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd3, 1'b0);
    stepCycle();
    checkOutput("crit_scaled_flush", int'(scaled_flush_threshold), 200000);
    checkOutput("crit_scaled_stall", int'(scaled_stall_threshold), 75000);
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
    stepCycle();
    checkOutput("stall_entry_state", int'(seq_state), 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
    cnt = 0;
    frozen = 1;
    for (int i = 0; i < 8; i++) begin
      if (pipe_stall) cnt++;
      if (seq_state == 3'd1 && scaled_flush_threshold != 21'd200000) frozen = 0;
      stepCycle();
    end
    checkOutput("stall_hold_cycles", cnt, 4);
    checkOutput("stall_thr_frozen", frozen, 1);
    checkOutput("stall_esc_count", int'(esc_count), 1);
    checkOutput("stall_back_idle", int'(seq_state), 0);
    checkOutput("high_scaled_flush", int'(scaled_flush_threshold), 300000);
    checkOutput("high_scaled_stall", int'(scaled_stall_threshold), 112500);

    // Two more episodes: the third escalates into a flush
    runEpisode();
    checkOutput("ep2_esc_count", int'(esc_count), 2);
    checkOutput("ep2_state", int'(seq_state), 0);
    runEpisode();
    checkOutput("ep3_escalated_state", int'(seq_state), 2);
    checkOutput("ep3_esc_cleared", int'(esc_count), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (pipe_flush_req) cnt++;
      if (i == 4) pipe_flush_ack = 1'b1;
      stepCycle();
    end
    pipe_flush_ack = 1'b0;
    checkOutput("flush_req_cycles", cnt, 5);
    checkOutput("ack_cooldown_state", int'(seq_state), 3);
    checkOutput("ack_flush_req_low", int'(pipe_flush_req), 0);
    checkOutput("ack_stall_low", int'(pipe_stall), 0);
    cnt = 0;
    for (int i = 0; i < 30 && seq_state == 3'd3; i++) begin
      cnt++;
      stepCycle();
    end
    checkOutput("cooldown_cycles", cnt, 8);
    checkOutput("cooldown_to_idle", int'(seq_state), 0);

    // Flush beats stall; cooldown ignores stalls and non-critical flushes
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd2, 1'b0);
    stepCycle();
    checkOutput("both_req_state", int'(seq_state), 2);
    checkOutput("both_req_stall", int'(pipe_stall), 1);
    checkOutput("both_req_flush", int'(pipe_flush_req), 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd2, 1'b1);
    stepCycle();
    checkOutput("ack2_state", int'(seq_state), 3);
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
    stepCycle();
    checkOutput("cd_stall_ignored", int'(seq_state), 3);
    checkOutput("cd_stall_out_low", int'(pipe_stall), 0);
    applyStimulus(1'b1, 1'b0, 2'd2, 2'd2, 1'b0);
    stepCycle();
    checkOutput("cd_med_flush_ignored", int'(seq_state), 3);
    applyStimulus(1'b1, 1'b0, 2'd3, 2'd2, 1'b0);
    stepCycle();
    checkOutput("cd_crit_flush_state", int'(seq_state), 2);
    checkOutput("cd_crit_flush_req", int'(pipe_flush_req), 1);

    // Async reset mid-handshake also restores the base thresholds
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    setCfg(1'b1, 2'd0, 21'd1000);
    stepCycle();
    setCfg(1'b1, 2'd1, 21'd2000);
    stepCycle();
    setCfg(1'b0, 2'd0, 21'd0);
    stepCycle();
    checkOutput("pre_rst_state", int'(seq_state), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_flush_req", int'(pipe_flush_req), 0);
    checkOutput("async_rst_state", int'(seq_state), 0);
    checkOutput("async_rst_stall", int'(pipe_stall), 0);
    stepCycle();
    rst = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rst_base_flush", int'(scaled_flush_threshold), 400000);
    checkOutput("rst_base_stall", int'(scaled_stall_threshold), 150000);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus($urandom_range(0, 23) == 0, $urandom_range(0, 3) == 0,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) setCfg(1'b1, 2'($urandom_range(0, 3)), 21'($urandom));
      else setCfg(1'b0, 2'd0, 21'd0);
      stepCycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
